// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS core: one instruction walks FETCH..WRITEBACK using req/valid memory handshakes.
// Includes the 32x32 register file (one write port, two registered read ports).
module mips_regfile (
  input  logic        clk,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);
  logic [31:0] r_mem [32];

  always_ff @(posedge clk) begin
    if (i_we && (i_waddr != 5'd0))
      r_mem[i_waddr] <= i_wdata;
    o_rdata1 <= (i_raddr1 == 5'd0) ? 32'd0 : r_mem[i_raddr1];
    o_rdata2 <= (i_raddr2 == 5'd0) ? 32'd0 : r_mem[i_raddr2];
  end
endmodule

module mips_mc_core #(
  parameter logic [31:0] pc_init = 32'h0,
  parameter logic [31:0] sp_init = 32'h0,
  parameter logic [31:0] ra_init = 32'h0,
  parameter int          CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             instr_req,
  output logic [31:0]      instr_addr,
  input  logic             instr_valid,
  input  logic [31:0]      instr_in,
  output logic             data_req,
  output logic             data_rd_wr,
  output logic [31:0]      data_addr,
  output logic [31:0]      data_out,
  input  logic             data_valid,
  input  logic [31:0]      data_in,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
);
  typedef enum logic [2:0] {S_INIT, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT} state_t;
  typedef enum logic [3:0] {OP_NOP, OP_ADD, OP_SUB, OP_SLT, OP_SLL, OP_LUI, OP_LW, OP_SW,
                            OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_JR, OP_BRK} op_t;

  state_t           r_state;
  op_t              r_op;
  logic [31:0]      r_pc, r_ir, r_result, r_next_pc, r_data_addr, r_data_out;
  logic [4:0]       r_wr_addr;
  logic             r_wr_en, r_use_imm, r_instr_req, r_data_req, r_data_rd_wr, r_halted;
  logic [CNT_W-1:0] r_retired;

  op_t         w_op;
  logic        w_wr_en, w_use_imm, w_rf_we;
  logic [4:0]  w_wr_addr, w_rf_wa;
  logic [31:0] w_rf_wd, w_rs_data, w_rt_data, w_imm, w_b, w_alu, w_pc4, w_next_pc;

  assign instr_req     = r_instr_req;
  assign instr_addr    = r_pc;
  assign data_req      = r_data_req;
  assign data_rd_wr    = r_data_rd_wr;
  assign data_addr     = r_data_addr;
  assign data_out      = r_data_out;
  assign halted        = r_halted;
  assign retired_count = r_retired;

  // Single write port shared by the reset-time r29 load, the INIT r31 load and writeback.
  always_comb begin
    w_rf_we = 1'b0;
    w_rf_wa = 5'd0;
    w_rf_wd = 32'd0;
    if (reset) begin
      w_rf_we = 1'b1; w_rf_wa = 5'd29; w_rf_wd = sp_init;
    end else if (r_state == S_INIT) begin
      w_rf_we = 1'b1; w_rf_wa = 5'd31; w_rf_wd = ra_init;
    end else if (r_state == S_WRITEBACK && r_wr_en) begin
      w_rf_we = 1'b1; w_rf_wa = r_wr_addr; w_rf_wd = r_result;
    end
  end

  mips_regfile u_regfile (
    .clk      (clk),
    .i_we     (w_rf_we),
    .i_waddr  (w_rf_wa),
    .i_wdata  (w_rf_wd),
    .i_raddr1 (r_ir[25:21]),
    .i_raddr2 (r_ir[20:16]),
    .o_rdata1 (w_rs_data),
    .o_rdata2 (w_rt_data)
  );

  always_comb begin
    w_op      = OP_NOP;
    w_wr_en   = 1'b0;
    w_wr_addr = r_ir[20:16];
    w_use_imm = 1'b1;
    case (r_ir[31:26])
      6'h00: begin
        w_use_imm = 1'b0;
        w_wr_addr = r_ir[15:11];
        case (r_ir[5:0])
          6'h20, 6'h21: begin w_op = OP_ADD; w_wr_en = 1'b1; end
          6'h22, 6'h23: begin w_op = OP_SUB; w_wr_en = 1'b1; end
          6'h2a:        begin w_op = OP_SLT; w_wr_en = 1'b1; end
          6'h00:        begin w_op = OP_SLL; w_wr_en = 1'b1; end
          6'h08:        w_op = OP_JR;
          6'h0d:        w_op = OP_BRK;
          default:      w_op = OP_NOP;
        endcase
      end
      6'h08, 6'h09: begin w_op = OP_ADD; w_wr_en = 1'b1; end
      6'h0f:        begin w_op = OP_LUI; w_wr_en = 1'b1; end
      6'h23:        begin w_op = OP_LW;  w_wr_en = 1'b1; end
      6'h2b:        w_op = OP_SW;
      6'h04:        w_op = OP_BEQ;
      6'h05:        w_op = OP_BNE;
      6'h02:        w_op = OP_J;
      6'h03:        begin w_op = OP_JAL; w_wr_en = 1'b1; w_wr_addr = 5'd31; end
      default:      w_op = OP_NOP;
    endcase
  end

  assign w_imm = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_b   = r_use_imm ? w_imm : w_rt_data;
  assign w_pc4 = r_pc + 32'd4;

  always_comb begin
    w_alu     = 32'd0;
    w_next_pc = w_pc4;
    case (r_op)
      OP_ADD, OP_LW, OP_SW: w_alu = w_rs_data + w_b;
      OP_SUB:  w_alu = w_rs_data - w_b;
      OP_SLT:  w_alu = {31'd0, $signed(w_rs_data) < $signed(w_b)};
      OP_SLL:  w_alu = w_rt_data << r_ir[10:6];
      OP_LUI:  w_alu = {r_ir[15:0], 16'h0000};
      OP_BEQ:  if (w_rs_data == w_rt_data) w_next_pc = w_pc4 + {w_imm[29:0], 2'b00};
      OP_BNE:  if (w_rs_data != w_rt_data) w_next_pc = w_pc4 + {w_imm[29:0], 2'b00};
      OP_J:    w_next_pc = {w_pc4[31:28], r_ir[25:0], 2'b00};
      OP_JAL: begin
        w_alu     = r_pc + 32'd8;
        w_next_pc = {w_pc4[31:28], r_ir[25:0], 2'b00};
      end
      OP_JR:   w_next_pc = w_rs_data;
      default: w_alu = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_INIT;
      r_pc         <= pc_init;
      r_instr_req  <= 1'b0;
      r_data_req   <= 1'b0;
      r_data_rd_wr <= 1'b1;
      r_data_addr  <= 32'd0;
      r_data_out   <= 32'd0;
      r_halted     <= 1'b0;
      r_retired    <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_state     <= S_FETCH;
          r_instr_req <= 1'b1;
        end
        S_FETCH: if (instr_valid) begin
          r_ir        <= instr_in;
          r_instr_req <= 1'b0;
          r_state     <= S_DECODE;
        end
        S_DECODE: begin
          r_op      <= w_op;
          r_wr_en   <= w_wr_en;
          r_wr_addr <= w_wr_addr;
          r_use_imm <= w_use_imm;
          r_state   <= S_EXECUTE;
        end
        S_EXECUTE: begin
          r_result  <= w_alu;
          r_next_pc <= w_next_pc;
          if (r_op == OP_BRK) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state <= S_MEMORY;
            if (r_op == OP_LW || r_op == OP_SW) begin
              r_data_req   <= 1'b1;
              r_data_rd_wr <= (r_op == OP_LW);
              r_data_addr  <= w_alu;
              r_data_out   <= w_rt_data;
            end
          end
        end
        S_MEMORY: begin
          if (!r_data_req) begin
            r_state <= S_WRITEBACK;
          end else if (data_valid) begin
            r_data_req   <= 1'b0;
            r_data_rd_wr <= 1'b1;
            if (r_data_rd_wr) r_result <= data_in;
            r_state      <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          r_pc        <= r_next_pc;
          r_retired   <= r_retired + CNT_W'(1);
          r_instr_req <= 1'b1;
          r_state     <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_INIT;
      endcase
    end
  end
endmodule
